// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for a 5-stage RV32I pipeline.
// Produces per-stage hold (stall) and NOP-insert (bubble) enables, handles
// load-use hazards, EX-resolved redirects (deferred while a fetch is in
// flight), fetch/memory wait cycles, and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       id_ra1,
  input  logic [4:0]       id_ra2,
  input  logic             ex_is_load,
  input  logic             ex_we,
  input  logic [4:0]       ex_wa,
  input  logic             ex_br_taken,
  input  logic [XLEN-1:0]  ex_br_target,
  input  logic             if_busy,
  input  logic             mm_busy,
  output logic [4:0]       stall,
  output logic [4:0]       bubble,
  output logic             redirect_en,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_PEND = 2'd1
  } state_t;

  // Stage bit positions: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
  localparam logic [4:0] MEM_WAIT_STALL  = 5'b01111;
  localparam logic [4:0] MEM_WAIT_BUBBLE = 5'b10000;
  localparam logic [4:0] FETCH_STALL     = 5'b00001;
  localparam logic [4:0] FETCH_BUBBLE    = 5'b00010;
  localparam logic [4:0] BRANCH_BUBBLE   = 5'b00110;
  localparam logic [4:0] LDUSE_STALL     = 5'b00011;
  localparam logic [4:0] LDUSE_BUBBLE    = 5'b00100;

  state_t            r_state;
  logic [XLEN-1:0]   r_target;
  logic [CNT_W-1:0]  r_cnt;

  state_t            w_state_next;
  logic              w_latch;
  logic [4:0]        w_stall;
  logic [4:0]        w_bubble;
  logic              w_redir_en;
  logic [XLEN-1:0]   w_redir_pc;
  logic              w_any;
  logic              w_load_use;

  logic [1:0]        w_src_re;
  logic [4:0]        w_src_ra [2];
  logic [1:0]        w_src_hit;

  assign w_src_re    = {id_re2, id_re1};
  assign w_src_ra[0] = id_ra1;
  assign w_src_ra[1] = id_ra2;

  // One comparator per decode source operand against the EX destination
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign w_src_hit[gi] = w_src_re[gi] & (w_src_ra[gi] == ex_wa);
    end
  endgenerate

  // x0 is hard-wired zero, so a load targeting it never creates a hazard
  assign w_load_use = ex_is_load & ex_we & (ex_wa != 5'd0) & (|w_src_hit);

  // Per-cycle priority resolution; memory wait dominates every state
  always_comb begin
    w_stall      = '0;
    w_bubble     = '0;
    w_redir_en   = 1'b0;
    w_redir_pc   = '0;
    w_state_next = r_state;
    w_latch      = 1'b0;
    if (mm_busy) begin
      // Freeze everything up to EX/MEM; a branch in EX is re-evaluated later
      w_stall  = MEM_WAIT_STALL;
      w_bubble = MEM_WAIT_BUBBLE;
    end else if (r_state == REDIR_PEND) begin
      // ID/EX only holds bubbles here, so ex_br_taken is deliberately ignored
      if (if_busy) begin
        w_stall  = FETCH_STALL;
        w_bubble = FETCH_BUBBLE;
      end else begin
        w_redir_en   = 1'b1;
        w_redir_pc   = r_target;
        w_bubble     = FETCH_BUBBLE;
        w_state_next = RUN;
      end
    end else if (ex_br_taken) begin
      w_bubble = BRANCH_BUBBLE;
      if (!if_busy) begin
        w_redir_en = 1'b1;
        w_redir_pc = ex_br_target;
      end else begin
        // Fetch in flight: remember the target and redirect once it lands
        w_latch      = 1'b1;
        w_state_next = REDIR_PEND;
      end
    end else if (w_load_use) begin
      // One cycle is enough: next cycle the load is in MEM and forwards
      w_stall  = LDUSE_STALL;
      w_bubble = LDUSE_BUBBLE;
    end else if (if_busy) begin
      w_stall  = FETCH_STALL;
      w_bubble = FETCH_BUBBLE;
    end
  end

  assign w_any = (|w_stall) | (|w_bubble);

  // Redirect FSM and pending-target register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= RUN;
      r_target <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_target <= ex_br_target;
      end
    end
  end

  // Saturating count of cycles with any hold or NOP-insert active
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_any && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // All outputs read as zero while reset is asserted
  assign stall       = rst ? w_stall    : 5'b0;
  assign bubble      = rst ? w_bubble   : 5'b0;
  assign redirect_en = rst ? w_redir_en : 1'b0;
  assign redirect_pc = rst ? w_redir_pc : '0;
  assign state       = rst ? r_state    : 2'd0;
  assign stall_cnt   = rst ? r_cnt      : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: one task per scenario, inline checks.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_re1, id_re2;
  logic [4:0]  id_ra1, id_ra2;
  logic        ex_is_load, ex_we;
  logic [4:0]  ex_wa;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        if_busy, mm_busy;
  logic [4:0]  stall, bubble;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  // Second instance with a 2-bit counter for the saturation check
  logic        rst_s;
  logic        if_busy_s;
  logic [4:0]  stall_s, bubble_s;
  logic        redirect_en_s;
  logic [31:0] redirect_pc_s;
  logic [1:0]  state_s;
  logic [1:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_re1(id_re1), .id_re2(id_re2), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_wa(ex_wa),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .if_busy(if_busy), .mm_busy(mm_busy),
    .stall(stall), .bubble(bubble),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .state(state), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst_s),
    .id_re1(1'b0), .id_re2(1'b0), .id_ra1(5'd0), .id_ra2(5'd0),
    .ex_is_load(1'b0), .ex_we(1'b0), .ex_wa(5'd0),
    .ex_br_taken(1'b0), .ex_br_target(32'd0),
    .if_busy(if_busy_s), .mm_busy(1'b0),
    .stall(stall_s), .bubble(bubble_s),
    .redirect_en(redirect_en_s), .redirect_pc(redirect_pc_s),
    .state(state_s), .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A taken branch must never reach EX while a redirect is pending
  always @(negedge clk) begin
    if (rst && state == 2'd1 && ex_br_taken) begin
      errors++;
      $display("FAIL br_in_pend got ex_br_taken=1 in state %0d exp no branch", state);
    end
  end

  task automatic clear_inputs();
    id_re1 = 0; id_re2 = 0; id_ra1 = 0; id_ra2 = 0;
    ex_is_load = 0; ex_we = 0; ex_wa = 0;
    ex_br_taken = 0; ex_br_target = 0;
    if_busy = 0; mm_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    if_busy = 1; ex_br_taken = 1; ex_br_target = 32'h44;
    next_cycle();
    #2;
    checks++; if (stall !== 5'b0) begin errors++; $display("FAIL rst_stall got %b exp %b", stall, 5'b0); end
    checks++; if (bubble !== 5'b0) begin errors++; $display("FAIL rst_bubble got %b exp %b", bubble, 5'b0); end
    checks++; if (redirect_en !== 1'b0) begin errors++; $display("FAIL rst_redir got %b exp 0", redirect_en); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt); end
    $display("txn reset stall=%b bubble=%b state=%0d cnt=%0d", stall, bubble, state, stall_cnt);
    clear_inputs();
    next_cycle();
    rst = 1;
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_rel_state got %0d exp 0", state); end
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_is_load = 1; ex_we = 1; ex_wa = 5; id_re1 = 1; id_ra1 = 5;
    #2;
    checks++; if (stall !== 5'b00011) begin errors++; $display("FAIL lu_stall got %b exp %b", stall, 5'b00011); end
    checks++; if (bubble !== 5'b00100) begin errors++; $display("FAIL lu_bubble got %b exp %b", bubble, 5'b00100); end
    $display("txn load_use stall=%b bubble=%b", stall, bubble);
    next_cycle();
    clear_inputs();
    #2;
    checks++; if (stall !== 5'b0) begin errors++; $display("FAIL lu_next_stall got %b exp %b", stall, 5'b0); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
    $display("txn load_use_after stall=%b cnt=%0d", stall, stall_cnt);
    next_cycle();
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    ex_is_load = 1; ex_we = 1; ex_wa = 0; id_re1 = 1; id_ra1 = 0;
    #2;
    checks++; if (stall !== 5'b0 || bubble !== 5'b0) begin errors++; $display("FAIL x0_hazard got stall=%b bubble=%b exp 0/0", stall, bubble); end
    $display("txn x0_load stall=%b bubble=%b", stall, bubble);
    ex_wa = 5; id_ra1 = 5; id_re1 = 0;
    #2;
    checks++; if (stall !== 5'b0 || bubble !== 5'b0) begin errors++; $display("FAIL noread_hazard got stall=%b bubble=%b exp 0/0", stall, bubble); end
    $display("txn no_read stall=%b bubble=%b", stall, bubble);
    ex_we = 0; id_re2 = 1; id_ra2 = 5;
    #2;
    checks++; if (stall !== 5'b0) begin errors++; $display("FAIL nowe_hazard got %b exp %b", stall, 5'b0); end
    ex_we = 1;
    #2;
    checks++; if (stall !== 5'b00011 || bubble !== 5'b00100) begin errors++; $display("FAIL rs2_hazard got stall=%b bubble=%b exp 00011/00100", stall, bubble); end
    $display("txn rs2_load_use stall=%b bubble=%b", stall, bubble);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_fetch_wait();
    clear_inputs();
    if_busy = 1;
    #2;
    checks++; if (stall !== 5'b00001 || bubble !== 5'b00010) begin errors++; $display("FAIL if_wait got stall=%b bubble=%b exp 00001/00010", stall, bubble); end
    $display("txn fetch_wait stall=%b bubble=%b", stall, bubble);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_branch_idle();
    clear_inputs();
    ex_br_taken = 1; ex_br_target = 32'h0000_0100;
    #2;
    checks++; if (redirect_en !== 1'b1) begin errors++; $display("FAIL br_idle_en got %b exp 1", redirect_en); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL br_idle_pc got %h exp %h", redirect_pc, 32'h100); end
    checks++; if (bubble !== 5'b00110 || stall !== 5'b0) begin errors++; $display("FAIL br_idle_ctl got stall=%b bubble=%b exp 00000/00110", stall, bubble); end
    $display("txn branch_idle en=%b pc=%h bubble=%b", redirect_en, redirect_pc, bubble);
    next_cycle();
    clear_inputs();
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL br_idle_state got %0d exp 0", state); end
  endtask

  task automatic test_branch_busy();
    clear_inputs();
    ex_br_taken = 1; ex_br_target = 32'h200; if_busy = 1;
    #2;
    checks++; if (redirect_en !== 1'b0 || bubble !== 5'b00110) begin errors++; $display("FAIL br_busy_first got en=%b bubble=%b exp 0/00110", redirect_en, bubble); end
    next_cycle();
    ex_br_taken = 0; ex_br_target = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL pend_state[%0d] got %0d exp 1", i, state); end
      checks++; if (stall !== 5'b00001 || bubble !== 5'b00010 || redirect_en !== 1'b0) begin
        errors++; $display("FAIL pend_wait[%0d] got stall=%b bubble=%b en=%b exp 00001/00010/0", i, stall, bubble, redirect_en);
      end
      $display("txn pend_wait %0d state=%0d stall=%b bubble=%b", i, state, stall, bubble);
      next_cycle();
    end
    mm_busy = 1;
    #2;
    checks++; if (stall !== 5'b01111 || bubble !== 5'b10000 || redirect_en !== 1'b0) begin
      errors++; $display("FAIL pend_mm got stall=%b bubble=%b en=%b exp 01111/10000/0", stall, bubble, redirect_en);
    end
    next_cycle();
    mm_busy = 0; if_busy = 0;
    #2;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL pend_mm_state got %0d exp 1", state); end
    checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL pend_redir got en=%b pc=%h exp 1/%h", redirect_en, redirect_pc, 32'h200); end
    checks++; if (bubble !== 5'b00010 || stall !== 5'b0) begin errors++; $display("FAIL pend_redir_ctl got stall=%b bubble=%b exp 00000/00010", stall, bubble); end
    $display("txn pend_redirect en=%b pc=%h", redirect_en, redirect_pc);
    next_cycle();
    clear_inputs();
    #2;
    checks++; if (state !== 2'd0 || redirect_en !== 1'b0) begin errors++; $display("FAIL pend_done got state=%0d en=%b exp 0/0", state, redirect_en); end
  endtask

  task automatic test_priority();
    clear_inputs();
    mm_busy = 1; ex_br_taken = 1; ex_br_target = 32'h300;
    ex_is_load = 1; ex_we = 1; ex_wa = 7; id_re1 = 1; id_ra1 = 7;
    #2;
    checks++; if (stall !== 5'b01111 || bubble !== 5'b10000) begin errors++; $display("FAIL prio_mm got stall=%b bubble=%b exp 01111/10000", stall, bubble); end
    checks++; if (redirect_en !== 1'b0) begin errors++; $display("FAIL prio_mm_en got %b exp 0", redirect_en); end
    $display("txn priority_mm stall=%b bubble=%b en=%b", stall, bubble, redirect_en);
    next_cycle();
    mm_busy = 0;
    #2;
    checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h300 || bubble !== 5'b00110) begin
      errors++; $display("FAIL prio_br got en=%b pc=%h bubble=%b exp 1/%h/00110", redirect_en, redirect_pc, bubble, 32'h300);
    end
    $display("txn priority_branch en=%b pc=%h", redirect_en, redirect_pc);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_pend();
    clear_inputs();
    ex_br_taken = 1; ex_br_target = 32'h400; if_busy = 1;
    next_cycle();
    ex_br_taken = 0;
    #2;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rmp_enter got %0d exp 1", state); end
    rst = 0;
    #2;
    checks++; if (stall !== 5'b0 || bubble !== 5'b0 || redirect_en !== 1'b0) begin
      errors++; $display("FAIL rmp_forced got stall=%b bubble=%b en=%b exp 0/0/0", stall, bubble, redirect_en);
    end
    next_cycle();
    rst = 1; if_busy = 0;
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rmp_state got %0d exp 0", state); end
    checks++; if (redirect_en !== 1'b0) begin errors++; $display("FAIL rmp_redir got %b exp 0", redirect_en); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rmp_cnt got %0d exp 0", stall_cnt); end
    $display("txn reset_mid_pend state=%0d en=%b cnt=%0d", state, redirect_en, stall_cnt);
    next_cycle();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    if_busy_s = 1;
    rst_s = 0;
    next_cycle();
    rst_s = 1;
    exp_cnt = 2'd0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      checks++; if (stall_cnt_s !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_cnt_s, exp_cnt); end
      $display("txn saturate %0d cnt=%0d", i, stall_cnt_s);
    end
    if_busy_s = 0;
  endtask

  initial begin
    rst = 0; rst_s = 0; if_busy_s = 0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_fetch_wait();
    test_branch_idle();
    test_branch_busy();
    test_priority();
    test_reset_mid_pend();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
